// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   - pc_sel encodings seen by the PC register (PC_HOLD / PC_INC / PC_LOAD)
//   - sequencer state type
//   - default reset / interrupt vectors and increment limit, also used by the
//     PC register and the stack unit
package pc_seq_pkg;

  localparam logic [1:0] PC_HOLD = 2'd0;
  localparam logic [1:0] PC_INC  = 2'd1;
  localparam logic [1:0] PC_LOAD = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_INT_PUSH   = 2'd1,
    ST_INT_VEC_LD = 2'd2,
    ST_RET_WAIT   = 2'd3
  } pc_seq_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'd32;
  localparam logic [31:0] DEF_INT_VEC   = 32'd0;
  localparam logic [31:0] DEF_PC_LIMIT  = 32'd50;

endpackage

// File: rtl/pc_seq_int_latch.sv
// pc_seq_int_latch: interrupt-pending latch and ISR mask / nesting depth.
// Build option: PC_SEQ_NESTED_INT_EN
//   undefined - single in-ISR bit; requests are ignored while it is set.
//   defined   - 4-bit nesting depth, saturating at 15; requests are masked
//               only at full depth.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   int_req      external interrupt request
//   vec_ld       sequencer is in the vector-load cycle (clears pending,
//                enters an ISR level)
//   rti_pop      RTI return address accepted (leaves an ISR level)
//   int_pending  latched, unmasked interrupt request
module pc_seq_int_latch (
  input  logic clk,
  input  logic reset,
  input  logic int_req,
  input  logic vec_ld,
  input  logic rti_pop,
  output logic int_pending
);

  logic masked;

`ifdef PC_SEQ_NESTED_INT_EN
  logic [3:0] isr_depth;

  assign masked = (isr_depth == 4'd15);

  always_ff @(posedge clk) begin
    if (reset)
      isr_depth <= 4'd0;
    else if (vec_ld && isr_depth != 4'd15)
      isr_depth <= isr_depth + 4'd1;
    else if (rti_pop && isr_depth != 4'd0)
      isr_depth <= isr_depth - 4'd1;
  end
`else
  logic in_isr;

  assign masked = in_isr;

  always_ff @(posedge clk) begin
    if (reset)
      in_isr <= 1'b0;
    else if (vec_ld)
      in_isr <= 1'b1;
    else if (rti_pop)
      in_isr <= 1'b0;
  end
`endif

  // The clear in the vector-load cycle wins: a request landing in that same
  // cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset)
      int_pending <= 1'b0;
    else if (vec_ld)
      int_pending <= 1'b0;
    else if (int_req && !masked)
      int_pending <= 1'b1;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: selects hold / increment / load for the PC register each
// cycle and sequences interrupt entry (push return PC, load vector) and
// return (pop PC from the stack).
// Redirect priority in RUN: return pop, interrupt entry, hazard stall,
// taken branch, sequential increment (only while cur_pc < PC_LIMIT).
// Build option: PC_SEQ_NESTED_INT_EN (interrupt nesting, see pc_seq_int_latch).
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cur_pc                           current PC register value
//   int_req, stall_hazard            interrupt request, hazard stall
//   branch_taken, branch_target      resolved taken branch and destination
//   ret_req, rti_req                 RET / RTI decoded (pulses)
//   push_ack, pop_valid, pop_data    stack handshake responses
//   pc_sel, pc_next                  PC register control and load value
//   flush                            squash fetch/decode
//   push_req, push_data, pop_req     stack handshake requests
//   int_ack                          pulse at interrupt vector load
//   busy                             sequencer outside RUN
//
// state         | meaning
// --------------+-----------------------------------------------
// ST_RUN        | normal fetch: increment, branch, stall
// ST_INT_PUSH   | pushing return PC, waiting for push_ack
// ST_INT_VEC_LD | one cycle: load interrupt vector, pulse int_ack
// ST_RET_WAIT   | pop requested, waiting for pop_valid
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] INT_VEC   = DEF_INT_VEC,
  parameter logic [31:0] PC_LIMIT  = DEF_PC_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cur_pc,
  input  logic        int_req,
  input  logic        stall_hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ret_req,
  input  logic        rti_req,
  input  logic        push_ack,
  input  logic        pop_valid,
  input  logic [31:0] pop_data,
  output logic [1:0]  pc_sel,
  output logic [31:0] pc_next,
  output logic        flush,
  output logic        push_req,
  output logic [31:0] push_data,
  output logic        pop_req,
  output logic        int_ack,
  output logic        busy
);

  pc_seq_state_e state, state_nxt;
  logic          is_rti, is_rti_nxt;
  logic          int_pending;
  logic          vec_ld;
  logic          rti_pop;

  pc_seq_int_latch u_int_latch (
    .clk         (clk),
    .reset       (reset),
    .int_req     (int_req),
    .vec_ld      (vec_ld),
    .rti_pop     (rti_pop),
    .int_pending (int_pending)
  );

  always_comb begin
    pc_sel     = PC_HOLD;
    pc_next    = 32'd0;
    flush      = 1'b0;
    push_req   = 1'b0;
    push_data  = 32'd0;
    pop_req    = 1'b0;
    int_ack    = 1'b0;
    vec_ld     = 1'b0;
    rti_pop    = 1'b0;
    state_nxt  = state;
    is_rti_nxt = is_rti;

    // Reset overrides the FSM combinationally so any outstanding stack
    // request is withdrawn in the same cycle.
    if (reset) begin
      pc_sel  = PC_LOAD;
      pc_next = RESET_VEC;
    end else begin
      case (state)
        ST_RUN: begin
          if (ret_req || rti_req) begin
            flush      = 1'b1;
            pop_req    = 1'b1;
            is_rti_nxt = rti_req;
            state_nxt  = ST_RET_WAIT;
          end else if (int_pending && !stall_hazard) begin
            flush     = 1'b1;
            state_nxt = ST_INT_PUSH;
          end else if (stall_hazard) begin
            pc_sel = PC_HOLD;
          end else if (branch_taken) begin
            pc_sel  = PC_LOAD;
            pc_next = branch_target;
            flush   = 1'b1;
          end else if (cur_pc < PC_LIMIT) begin
            pc_sel = PC_INC;
          end
        end
        ST_INT_PUSH: begin
          // PC is held here, so cur_pc is stable until the push is accepted.
          push_req  = 1'b1;
          push_data = cur_pc;
          flush     = 1'b1;
          if (push_ack)
            state_nxt = ST_INT_VEC_LD;
        end
        ST_INT_VEC_LD: begin
          pc_sel    = PC_LOAD;
          pc_next   = INT_VEC;
          int_ack   = 1'b1;
          vec_ld    = 1'b1;
          state_nxt = ST_RUN;
        end
        ST_RET_WAIT: begin
          if (pop_valid) begin
            pc_sel    = PC_LOAD;
            pc_next   = pop_data;
            rti_pop   = is_rti;
            state_nxt = ST_RUN;
          end else begin
            pop_req = 1'b1;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign busy = !reset && (state != ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_RUN;
      is_rti <= 1'b0;
    end else begin
      state  <= state_nxt;
      is_rti <= is_rti_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic checked
// against a cycle-level reference model; the bench also plays the PC
// register so cur_pc follows the expected pc_sel/pc_next.
module tb_pc_sequencer;

  localparam logic [1:0]  S_HOLD = 2'd0;
  localparam logic [1:0]  S_INC  = 2'd1;
  localparam logic [1:0]  S_LOAD = 2'd2;
  localparam logic [31:0] RV     = 32'd32;
  localparam logic [31:0] IV     = 32'd0;
  localparam logic [31:0] LIM    = 32'd50;
`ifdef PC_SEQ_NESTED_INT_EN
  localparam int MAXD = 15;
  localparam bit NESTED = 1'b1;
`else
  localparam int MAXD = 1;
  localparam bit NESTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cur_pc;
  logic        int_req, stall_hazard, branch_taken;
  logic [31:0] branch_target;
  logic        ret_req, rti_req, push_ack, pop_valid;
  logic [31:0] pop_data;
  logic [1:0]  pc_sel;
  logic [31:0] pc_next;
  logic        flush, push_req;
  logic [31:0] push_data;
  logic        pop_req, int_ack, busy;

  int n_chk = 0;
  int n_fail = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .cur_pc(cur_pc), .int_req(int_req),
    .stall_hazard(stall_hazard), .branch_taken(branch_taken),
    .branch_target(branch_target), .ret_req(ret_req), .rti_req(rti_req),
    .push_ack(push_ack), .pop_valid(pop_valid), .pop_data(pop_data),
    .pc_sel(pc_sel), .pc_next(pc_next), .flush(flush), .push_req(push_req),
    .push_data(push_data), .pop_req(pop_req), .int_ack(int_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // packed view: {pc_sel, pc_next, push_data, flush, push_req, pop_req, int_ack, busy}
  function automatic logic [70:0] mk(logic [1:0] s, logic [31:0] n, logic [31:0] pd, logic [4:0] f);
    return {s, n, pd, f};
  endfunction

  function automatic logic [70:0] obs();
    return {pc_sel, pc_next, push_data, flush, push_req, pop_req, int_ack, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    int_req = 0; stall_hazard = 0; branch_taken = 0; branch_target = 0;
    ret_req = 0; rti_req = 0; push_ack = 0; pop_valid = 0; pop_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [70:0] e;
    clear_inputs();
    reset = 1; cur_pc = 32'd32;
    #2; e = mk(S_LOAD, RV, 0, 5'b00000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL reset_out: got %h want %h", obs(), e); end
    tick(); reset = 0;
    for (int i = 0; i < 3; i++) begin
      #2; e = mk(S_INC, 0, 0, 5'b00000);
      n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL inc_after_reset[%0d]: got %h want %h", i, obs(), e); end
      tick();
    end
    cur_pc = 32'd50; #2; e = mk(S_HOLD, 0, 0, 5'b00000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL hold_at_limit: got %h want %h", obs(), e); end
    tick();
    cur_pc = 32'd49; #2; e = mk(S_INC, 0, 0, 5'b00000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL inc_below_limit: got %h want %h", obs(), e); end
    tick();
    cur_pc = 32'hFFFF_FFFF; #2; e = mk(S_HOLD, 0, 0, 5'b00000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL hold_unsigned_max: got %h want %h", obs(), e); end
    tick();
  endtask

  task automatic test_branch_stall();
    logic [70:0] e;
    do_reset();
    cur_pc = 32'd32; branch_taken = 1; branch_target = 32'h40; stall_hazard = 1;
    #2; e = mk(S_HOLD, 0, 0, 5'b00000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL branch_under_stall: got %h want %h", obs(), e); end
    tick(); stall_hazard = 0;
    #2; e = mk(S_LOAD, 32'h40, 0, 5'b10000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL branch_load: got %h want %h", obs(), e); end
    tick(); branch_taken = 0; cur_pc = 32'h40;
    #2; e = mk(S_HOLD, 0, 0, 5'b00000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL hold_above_limit: got %h want %h", obs(), e); end
    tick();
  endtask

  task automatic test_interrupt_entry();
    logic [70:0] e;
    do_reset();
    cur_pc = 32'h25; int_req = 1;
    #2; e = mk(S_INC, 0, 0, 5'b00000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL int_req_cycle: got %h want %h", obs(), e); end
    tick(); int_req = 0;
    #2; e = mk(S_HOLD, 0, 0, 5'b10000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL int_enter: got %h want %h", obs(), e); end
    tick(); branch_taken = 1; branch_target = 32'h40;
    #2; e = mk(S_HOLD, 0, 32'h25, 5'b11001);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL push_wait: got %h want %h", obs(), e); end
    tick(); branch_taken = 0; push_ack = 1;
    #2; e = mk(S_HOLD, 0, 32'h25, 5'b11001);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL push_ack_cycle: got %h want %h", obs(), e); end
    tick(); push_ack = 0;
    #2; e = mk(S_LOAD, IV, 0, 5'b00011);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL vector_load: got %h want %h", obs(), e); end
    tick(); cur_pc = IV;
    #2; e = mk(S_INC, 0, 0, 5'b00000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL isr_run: got %h want %h", obs(), e); end
    tick();
  endtask

  // Runs straight after test_interrupt_entry, inside the ISR.
  task automatic test_rti();
    logic [70:0] e;
    bit hold_int;
    hold_int = !NESTED;
    cur_pc = 32'd1; int_req = hold_int;
    for (int i = 0; i < 2; i++) begin
      #2; e = mk(S_INC, 0, 0, 5'b00000);
      n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL masked_in_isr[%0d]: got %h want %h", i, obs(), e); end
      tick();
    end
    rti_req = 1;
    #2; e = mk(S_HOLD, 0, 0, 5'b10100);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL rti_pop_req: got %h want %h", obs(), e); end
    tick(); rti_req = 0;
    for (int i = 0; i < 2; i++) begin
      #2; e = mk(S_HOLD, 0, 0, 5'b00101);
      n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL pop_wait[%0d]: got %h want %h", i, obs(), e); end
      tick();
    end
    pop_valid = 1; pop_data = 32'h26;
    #2; e = mk(S_LOAD, 32'h26, 0, 5'b00001);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL rti_load: got %h want %h", obs(), e); end
    tick(); pop_valid = 0; cur_pc = 32'h26;
    #2; e = mk(S_INC, 0, 0, 5'b00000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL post_rti_run: got %h want %h", obs(), e); end
    tick(); cur_pc = 32'h27;
    #2; e = hold_int ? mk(S_HOLD, 0, 0, 5'b10000) : mk(S_INC, 0, 0, 5'b00000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL int_after_rti: got %h want %h", obs(), e); end
    tick(); int_req = 0;
  endtask

  task automatic test_ret_vs_int();
    logic [70:0] e;
    do_reset();
    cur_pc = 32'h30; int_req = 1;
    tick(); int_req = 0; ret_req = 1;
    #2; e = mk(S_HOLD, 0, 0, 5'b10100);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL ret_wins: got %h want %h", obs(), e); end
    tick(); ret_req = 0; pop_valid = 1; pop_data = 32'h33;
    #2; e = mk(S_LOAD, 32'h33, 0, 5'b00001);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL ret_load: got %h want %h", obs(), e); end
    tick(); pop_valid = 0; cur_pc = 32'h33;
    #2; e = mk(S_HOLD, 0, 0, 5'b10000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL int_after_ret: got %h want %h", obs(), e); end
    tick();
    #2; e = mk(S_HOLD, 0, 32'h33, 5'b11001);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL push_after_ret: got %h want %h", obs(), e); end
    tick();
  endtask

  task automatic test_reset_mid_push();
    logic [70:0] e;
    do_reset();
    cur_pc = 32'h10; int_req = 1;
    tick(); int_req = 0;
    tick();
    #2; e = mk(S_HOLD, 0, 32'h10, 5'b11001);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL in_push: got %h want %h", obs(), e); end
    reset = 1;
    #1; e = mk(S_LOAD, RV, 0, 5'b00000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL reset_abort: got %h want %h", obs(), e); end
    tick(); reset = 0; cur_pc = RV;
    for (int i = 0; i < 2; i++) begin
      #2; e = mk(S_INC, 0, 0, 5'b00000);
      n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL pending_cleared[%0d]: got %h want %h", i, obs(), e); end
      tick();
    end
  endtask

  // Plain RET keeps the ISR mask; RET+RTI together acts as RTI and drops it.
  task automatic test_ret_rti_both();
    logic [70:0] e;
    do_reset();
    cur_pc = 32'h20; int_req = 1;
    tick(); int_req = 0;
    tick(); push_ack = 1;
    tick(); push_ack = 0;
    tick(); ret_req = 1;
    tick(); ret_req = 0; pop_valid = 1; pop_data = 32'h21;
    tick(); pop_valid = 0; cur_pc = 32'h21; int_req = 1;
    for (int i = 0; i < 2; i++) begin
      #2; e = mk(S_INC, 0, 0, 5'b00000);
      n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL ret_keeps_mask[%0d]: got %h want %h", i, obs(), e); end
      tick();
    end
    int_req = 0; ret_req = 1; rti_req = 1;
    tick(); ret_req = 0; rti_req = 0; pop_valid = 1; pop_data = 32'h22;
    tick(); pop_valid = 0; cur_pc = 32'h22; int_req = 1;
    tick(); int_req = 0;
    #2; e = mk(S_HOLD, 0, 0, 5'b10000);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL both_acts_as_rti: got %h want %h", obs(), e); end
    tick();
  endtask

  // Reference model: which phase of a redirect sequence we are in, a
  // pending-interrupt bit, and ISR depth as an integer capped at MAXD.
  localparam int P_RUN = 0, P_PUSH = 1, P_VEC = 2, P_POP = 3;
  int          m_phase, m_depth;
  bit          m_pend, m_rti;
  logic [31:0] m_pc;

  task automatic test_random();
    logic [70:0] e;
    int          n_phase, n_depth;
    bit          n_pend, n_rti;
    do_reset();
    m_phase = P_RUN; m_depth = 0; m_pend = 0; m_rti = 0; m_pc = RV;
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(63) == 0);
      int_req       = ($urandom_range(11) == 0);
      stall_hazard  = ($urandom_range(3) == 0);
      branch_taken  = ($urandom_range(5) == 0);
      branch_target = 32'($urandom_range(63));
      ret_req       = ($urandom_range(19) == 0);
      rti_req       = ($urandom_range(19) == 0);
      push_ack      = ($urandom_range(1) == 0);
      pop_valid     = ($urandom_range(2) == 0);
      pop_data      = 32'($urandom_range(63));
      cur_pc        = m_pc;

      n_phase = m_phase; n_depth = m_depth; n_pend = m_pend; n_rti = m_rti;
      e = mk(S_HOLD, 0, 0, 5'b00000);
      if (reset) begin
        e = mk(S_LOAD, RV, 0, 5'b00000);
        n_phase = P_RUN; n_depth = 0; n_pend = 0; n_rti = 0;
      end else begin
        if (m_phase == P_VEC) n_pend = 0;
        else if (int_req && m_depth < MAXD) n_pend = 1;
        case (m_phase)
          P_RUN:
            if (ret_req || rti_req) begin
              e = mk(S_HOLD, 0, 0, 5'b10100); n_rti = rti_req; n_phase = P_POP;
            end else if (m_pend && !stall_hazard) begin
              e = mk(S_HOLD, 0, 0, 5'b10000); n_phase = P_PUSH;
            end else if (stall_hazard) e = mk(S_HOLD, 0, 0, 5'b00000);
            else if (branch_taken) e = mk(S_LOAD, branch_target, 0, 5'b10000);
            else if (cur_pc < LIM) e = mk(S_INC, 0, 0, 5'b00000);
          P_PUSH: begin
            e = mk(S_HOLD, 0, cur_pc, 5'b11001);
            if (push_ack) n_phase = P_VEC;
          end
          P_VEC: begin
            e = mk(S_LOAD, IV, 0, 5'b00011);
            n_depth = (m_depth + 1 > MAXD) ? MAXD : m_depth + 1;
            n_phase = P_RUN;
          end
          default:
            if (pop_valid) begin
              e = mk(S_LOAD, pop_data, 0, 5'b00001);
              if (m_rti && m_depth > 0) n_depth = m_depth - 1;
              n_phase = P_RUN;
            end else e = mk(S_HOLD, 0, 0, 5'b00101);
        endcase
      end

      #2;
      n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL random[%0d]: got %h want %h", c, obs(), e); end
      tick();
      m_phase = n_phase; m_depth = n_depth; m_pend = n_pend; m_rti = n_rti;
      if (e[70:69] == S_INC) m_pc = m_pc + 32'd1;
      else if (e[70:69] == S_LOAD) m_pc = e[68:37];
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_branch_stall();
    test_interrupt_entry();
    test_rti();
    test_ret_vs_int();
    test_reset_mid_push();
`ifndef PC_SEQ_NESTED_INT_EN
    test_ret_rti_both();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control block that drives the program-counter register each cycle.
- Chooses among hold, increment or load of a new PC.
- Arbitrates the PC-redirect sources in a fixed priority: reset vector, return-address pop (RET/RTI), interrupt entry, hazard stall, taken branch, sequential increment.
- Sequences multi-cycle interrupt entry (push return PC, then vector) and return (pop PC from stack memory). Issues pipeline flush and stack push/pop handshakes.

Parameters:
- RESET_VEC, 32'd32, PC loaded on reset.
- INT_VEC, 32'd0, PC loaded on interrupt entry.
- PC_LIMIT, 32'd50, increment allowed only while cur_pc < PC_LIMIT; otherwise hold.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cur_pc  in  32  current PC register value.
- int_req  in  1  external interrupt request (level or pulse).
- stall_hazard  in  1  hazard unit stall.
- branch_taken  in  1  taken branch/jump resolved this cycle.
- branch_target  in  32  branch destination.
- ret_req  in  1  RET decoded (one-cycle pulse).
- rti_req  in  1  RTI decoded (one-cycle pulse).
- push_ack  in  1  stack accepted push.
- pop_valid  in  1  pop_data valid.
- pop_data  in  32  popped return address.
- pc_sel  out  2  0=HOLD, 1=INC, 2=LOAD (3 reserved, never driven).
- pc_next  out  32  load value; 0 unless pc_sel=LOAD.
- flush  out  1  squash fetch/decode stages.
- push_req  out  1  stack push request.
- push_data  out  32  value to push.
- pop_req  out  1  stack pop request.
- int_ack  out  1  one-cycle pulse at vector load.
- busy  out  1  high in any state other than RUN.

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- State register: RUN, INT_PUSH, INT_VEC_LD, RET_WAIT. Internal flags: int_pending, in_isr, is_rti.
- Outputs are combinational from state, flags and inputs.
- While reset is high:
  - pc_sel=LOAD, pc_next=RESET_VEC; all other outputs 0.
  - At the clock edge: state<=RUN, all flags cleared.
- int_pending:
  - Set on any cycle with int_req=1 and not masked.
  - Masked while in_isr=1 (see optional feature).
  - Cleared in INT_VEC_LD.
  - A request arriving in the same cycle as the clear is lost.
- RUN, first match wins:
  1. ret_req|rti_req: pc_sel=HOLD, flush=1, pop_req=1; is_rti<=rti_req; go RET_WAIT.
  2. int_pending & !stall_hazard: pc_sel=HOLD, flush=1; go INT_PUSH.
  3. stall_hazard: pc_sel=HOLD.
  4. branch_taken: pc_sel=LOAD, pc_next=branch_target, flush=1.
  5. cur_pc<PC_LIMIT (unsigned): pc_sel=INC.
  6. Otherwise: pc_sel=HOLD.
- INT_PUSH:
  - push_req=1, push_data=cur_pc, pc_sel=HOLD, flush=1.
  - push_req and push_data stay stable until push_ack.
  - On push_ack: go INT_VEC_LD.
  - A branch_taken arriving here is ignored; that instruction is flushed.
- INT_VEC_LD (exactly 1 cycle):
  - pc_sel=LOAD, pc_next=INT_VEC, int_ack=1.
  - int_pending<=0, in_isr<=1; go RUN.
- RET_WAIT:
  - pop_req=1 and pc_sel=HOLD until pop_valid.
  - On pop_valid (may come the cycle after entry): pc_sel=LOAD, pc_next=pop_data; if is_rti then in_isr<=0; go RUN.
  - int_pending may set during RET_WAIT but is serviced only in RUN.
- Latency:
  - Branch redirect: 0 cycles (same cycle).
  - Interrupt entry: at least 2 cycles after int_pending is seen in RUN (INT_PUSH ≥1 cycle, then INT_VEC_LD).
  - Return: at least 1 cycle after the ret pulse.
- Reset mid-sequence: aborts immediately. Outstanding push/pop requests drop the same cycle; the stack side must tolerate a withdrawn request.
- Simultaneous ret_req and rti_req: treated as RTI.

Optional Feature:
- Macro: PC_SEQ_NESTED_INT_EN.
- When defined:
  - int_req is not masked by in_isr, so interrupts can nest.
  - in_isr becomes a 4-bit depth counter: +1 at INT_VEC_LD, -1 at RTI pop. It saturates at 15, and further interrupts are masked at 15.
- When undefined:
  - in_isr is a single bit.
  - int_req is ignored while in_isr=1.

Decomposition:
- Shared package pc_seq_pkg:
  - pc_sel encoding constants (PC_HOLD, PC_INC, PC_LOAD).
  - State enum typedef.
  - Default vector constants, shared with the PC register and the stack unit.
- One natural sub-module: pc_seq_int_latch. It holds int_pending and the in_isr mask/depth logic, so the nesting feature is isolated there.

Test Plan:
- Reset, then release with cur_pc=32 and no events: first cycle pc_sel=LOAD, pc_next=32; then pc_sel=INC each cycle. With cur_pc=50: pc_sel=HOLD.
- branch_taken=1, target=0x40, together with stall_hazard=1: pc_sel=HOLD, no flush. Next cycle with stall=0: pc_sel=LOAD 0x40, flush=1.
- int_req pulse at cur_pc=0x25, push_ack after 2 cycles:
  - Cycle 1: HOLD+flush.
  - Cycles 2–3: push_req=1 with push_data=0x25.
  - Following cycle: LOAD 0 and int_ack=1; busy low afterwards.
- rti_req, pop_valid 3 cycles later with pop_data=0x26: pop_req high for 3 cycles, then LOAD 0x26, in_isr cleared. A second int_req during the ISR is serviced only after the RTI (non-nested build).
- ret_req and int_pending in the same RUN cycle: the return is served first (LOAD pop_data), then the interrupt entry starts on the next RUN cycle.
- Reset asserted in INT_PUSH while push_req=1: the next cycle has push_req=0, pc_sel=LOAD RESET_VEC, and int_pending cleared.
